// File: rtl/trap_ctrl.sv
// Trap controller: arbitrates synchronous exceptions against M-mode interrupts,
// drains the pipeline for interrupts, commits the trap and redirects fetch.
module trap_ctrl #(
  parameter bit VECTOR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pmode,
  input  logic        mstatus_mie,
  input  logic [63:0] mie,
  input  logic        irq_msi,
  input  logic        irq_mti,
  input  logic        irq_mei,
  input  logic [63:0] mtvec,
  input  logic        exc_valid,
  input  logic [5:0]  exc_code,
  input  logic [63:0] exc_pc,
  input  logic        drain_ack,
  input  logic [63:0] drain_pc,
  output logic        stall_req,
  output logic        trap_valid,
  output logic [5:0]  trap_code,
  output logic        trap_is_exc,
  output logic [63:0] trap_pc,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic [63:0] mip_view,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_COMMIT,
    S_REDIR
  } state_t;

  state_t      r_state;
  logic [63:0] r_mip;
  logic        r_stall;
  logic        r_busy;
  logic        r_trap_valid;
  logic [5:0]  r_code;
  logic        r_is_exc;
  logic [63:0] r_pc;
  logic        r_redir_valid;
  logic [63:0] r_rpc;

  logic [63:0] w_pend;
  logic        w_take;
  logic [5:0]  w_code;
  logic [63:0] w_base;
  logic [63:0] w_target;

  always_comb begin
    w_pend = r_mip & mie;
    w_take = (|w_pend) && ((pmode == 2'd0) || mstatus_mie);
    w_code = 6'd7;
    priority case (1'b1)
      w_pend[11]: w_code = 6'd11;
      w_pend[3]:  w_code = 6'd3;
      default:    w_code = 6'd7;
    endcase
  end

  // Vectored offset applies to interrupts only; modes 2/3 fall back to direct
  always_comb begin
    w_base   = {mtvec[63:2], 2'b00};
    w_target = w_base;
    if (VECTOR_EN && (mtvec[1:0] == 2'b01) && !r_is_exc)
      w_target = w_base + {56'd0, r_code, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_mip         <= 64'd0;
      r_stall       <= 1'b0;
      r_busy        <= 1'b0;
      r_trap_valid  <= 1'b0;
      r_code        <= 6'd0;
      r_is_exc      <= 1'b0;
      r_pc          <= 64'd0;
      r_redir_valid <= 1'b0;
      r_rpc         <= 64'd0;
    end else begin
      r_mip <= {52'd0, irq_mei, 3'd0, irq_mti,
                3'd0, irq_msi, 3'd0};
      r_trap_valid  <= 1'b0;
      r_redir_valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DRAIN: begin
          if (exc_valid) begin
            r_code       <= exc_code;
            r_pc         <= exc_pc;
            r_is_exc     <= 1'b1;
            r_state      <= S_COMMIT;
            r_trap_valid <= 1'b1;
            r_stall      <= 1'b1;
            r_busy       <= 1'b1;
          end else if (r_state == S_IDLE) begin
            if (w_take) begin
              r_code   <= w_code;
              r_is_exc <= 1'b0;
              r_state  <= S_DRAIN;
              r_stall  <= 1'b1;
              r_busy   <= 1'b1;
            end
          end else if (!w_take) begin
            r_state <= S_IDLE;
            r_stall <= 1'b0;
            r_busy  <= 1'b0;
          end else if (drain_ack) begin
            r_pc         <= drain_pc;
            r_state      <= S_COMMIT;
            r_trap_valid <= 1'b1;
          end else begin
            r_code <= w_code;
          end
        end
        S_COMMIT: begin
          r_rpc         <= w_target;
          r_state       <= S_REDIR;
          r_redir_valid <= 1'b1;
        end
        S_REDIR: begin
          r_state <= S_IDLE;
          r_stall <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req      = r_stall;
  assign busy           = r_busy;
  assign trap_valid     = r_trap_valid;
  assign trap_code      = r_code;
  assign trap_is_exc    = r_is_exc;
  assign trap_pc        = r_pc;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_rpc;
  assign mip_view       = r_mip;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural trap model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pmode;
  logic        mstatus_mie;
  logic [63:0] mie;
  logic        irq_msi, irq_mti, irq_mei;
  logic [63:0] mtvec;
  logic        exc_valid;
  logic [5:0]  exc_code;
  logic [63:0] exc_pc;
  logic        drain_ack;
  logic [63:0] drain_pc;
  logic        stall_req, trap_valid, trap_is_exc;
  logic [5:0]  trap_code;
  logic [63:0] trap_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] mip_view;
  logic        busy;

  int total = 0;
  int bad = 0;

  trap_ctrl #(.VECTOR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .pmode(pmode),
    .mstatus_mie(mstatus_mie), .mie(mie),
    .irq_msi(irq_msi), .irq_mti(irq_mti),
    .irq_mei(irq_mei), .mtvec(mtvec),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .drain_ack(drain_ack),
    .drain_pc(drain_pc), .stall_req(stall_req),
    .trap_valid(trap_valid), .trap_code(trap_code),
    .trap_is_exc(trap_is_exc), .trap_pc(trap_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .mip_view(mip_view), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    pmode = 2'd0; mstatus_mie = 1'b0; mie = 64'd0;
    irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
    mtvec = 64'd0; exc_valid = 1'b0; exc_code = 6'd0;
    exc_pc = 64'd0; drain_ack = 1'b0; drain_pc = 64'd0;
  endtask

  task automatic do_reset;
    clr_in();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clr_in();
    irq_msi = 1; irq_mti = 1; irq_mei = 1;
    mie = '1; mstatus_mie = 1; exc_valid = 1;
    exc_code = 6'd9; exc_pc = 64'h1234;
    rst = 1'b1;
    tick();
    total++;
    if ({stall_req, busy, trap_valid, redirect_valid} !== 4'b0 ||
        trap_code !== 6'd0 || trap_is_exc !== 1'b0 ||
        trap_pc !== 64'd0 || redirect_pc !== 64'd0 ||
        mip_view !== 64'd0) begin
      bad++;
      $display("FAIL reset_state: st=%b bz=%b tv=%b rv=%b code=%0d pc=%h rpc=%h mip=%h want all 0",
               stall_req, busy, trap_valid, redirect_valid,
               trap_code, trap_pc, redirect_pc, mip_view);
    end
    rst = 1'b0;
    clr_in();
    tick();
    total++;
    if (trap_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_trap: tv=%b busy=%b want 0 0",
               trap_valid, busy);
    end
  endtask

  task automatic test_exc;
    do_reset();
    mtvec = 64'h8000_0100;
    exc_valid = 1; exc_code = 6'd2; exc_pc = 64'h8000_0010;
    tick();
    exc_valid = 0;
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd2 ||
        trap_is_exc !== 1 || trap_pc !== 64'h8000_0010 ||
        stall_req !== 1 || redirect_valid !== 0) begin
      bad++;
      $display("FAIL exc_commit: tv=%b code=%0d exc=%b pc=%h st=%b rv=%b want 1 2 1 80000010 1 0",
               trap_valid, trap_code, trap_is_exc, trap_pc,
               stall_req, redirect_valid);
    end
    tick();
    total++;
    if (redirect_valid !== 1 || trap_valid !== 0 ||
        redirect_pc !== 64'h8000_0100) begin
      bad++;
      $display("FAIL exc_redir: rv=%b tv=%b rpc=%h want 1 0 80000100",
               redirect_valid, trap_valid, redirect_pc);
    end
    tick();
    total++;
    if (redirect_valid !== 0 || busy !== 0 || stall_req !== 0) begin
      bad++;
      $display("FAIL exc_idle: rv=%b busy=%b st=%b want 0 0 0",
               redirect_valid, busy, stall_req);
    end
  endtask

  task automatic test_int_vec;
    do_reset();
    pmode = 2'd3; mstatus_mie = 1; mie = 64'h80;
    mtvec = 64'h8000_0001; irq_mti = 1;
    tick();
    total++;
    if (mip_view !== 64'h80 || stall_req !== 0) begin
      bad++;
      $display("FAIL int_mip: mip=%h st=%b want 80 0",
               mip_view, stall_req);
    end
    tick();
    total++;
    if (stall_req !== 1 || busy !== 1 || trap_valid !== 0) begin
      bad++;
      $display("FAIL int_stall: st=%b busy=%b tv=%b want 1 1 0",
               stall_req, busy, trap_valid);
    end
    drain_ack = 1; drain_pc = 64'h100;
    tick();
    drain_ack = 0; irq_mti = 0;
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd7 ||
        trap_is_exc !== 0 || trap_pc !== 64'h100) begin
      bad++;
      $display("FAIL int_commit: tv=%b code=%0d exc=%b pc=%h want 1 7 0 100",
               trap_valid, trap_code, trap_is_exc, trap_pc);
    end
    tick();
    total++;
    if (redirect_valid !== 1 || trap_valid !== 0 ||
        redirect_pc !== 64'h8000_001C) begin
      bad++;
      $display("FAIL int_redir: rv=%b tv=%b rpc=%h want 1 0 8000001c",
               redirect_valid, trap_valid, redirect_pc);
    end
    tick();
    total++;
    if (busy !== 0 || redirect_valid !== 0) begin
      bad++;
      $display("FAIL int_idle: busy=%b rv=%b want 0 0",
               busy, redirect_valid);
    end
  endtask

  task automatic test_priority;
    do_reset();
    pmode = 2'd3; mstatus_mie = 1; mie = 64'h880;
    mtvec = 64'h1000; irq_mti = 1; irq_mei = 1;
    tick(); tick();
    drain_ack = 1; drain_pc = 64'h40;
    tick();
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd11) begin
      bad++;
      $display("FAIL prio_same: tv=%b code=%0d want 1 11",
               trap_valid, trap_code);
    end
    do_reset();
    pmode = 2'd3; mstatus_mie = 1; mie = 64'h880;
    mtvec = 64'h1000; irq_mti = 1;
    tick(); tick();
    irq_mei = 1;
    tick(); tick();
    drain_ack = 1; drain_pc = 64'h44;
    tick();
    drain_ack = 0; irq_mti = 0; irq_mei = 0;
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd11 ||
        trap_pc !== 64'h44) begin
      bad++;
      $display("FAIL prio_mid: tv=%b code=%0d pc=%h want 1 11 44",
               trap_valid, trap_code, trap_pc);
    end
    tick();
    total++;
    if (redirect_valid !== 1 || redirect_pc !== 64'h1000) begin
      bad++;
      $display("FAIL prio_direct: rv=%b rpc=%h want 1 1000",
               redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_gate;
    do_reset();
    pmode = 2'd3; mstatus_mie = 0; mie = 64'h80; irq_mti = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (busy !== 0 || stall_req !== 0) begin
        bad++;
        $display("FAIL gate_masked: cyc=%0d busy=%b st=%b want 0 0",
                 i, busy, stall_req);
      end
    end
    pmode = 2'd0;
    tick();
    total++;
    if (busy !== 1 || stall_req !== 1) begin
      bad++;
      $display("FAIL gate_umode: busy=%b st=%b want 1 1",
               busy, stall_req);
    end
    drain_ack = 1; drain_pc = 64'h300;
    tick();
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd7 ||
        trap_pc !== 64'h300) begin
      bad++;
      $display("FAIL gate_commit: tv=%b code=%0d pc=%h want 1 7 300",
               trap_valid, trap_code, trap_pc);
    end
  endtask

  task automatic test_drop;
    do_reset();
    pmode = 2'd3; mstatus_mie = 1; mie = 64'h8; irq_msi = 1;
    tick(); tick();
    irq_msi = 0;
    tick();
    total++;
    if (busy !== 1 || trap_valid !== 0) begin
      bad++;
      $display("FAIL drop_hold: busy=%b tv=%b want 1 0",
               busy, trap_valid);
    end
    tick();
    total++;
    if (busy !== 0 || stall_req !== 0 || trap_valid !== 0) begin
      bad++;
      $display("FAIL drop_idle: busy=%b st=%b tv=%b want 0 0 0",
               busy, stall_req, trap_valid);
    end
    tick();
    total++;
    if (trap_valid !== 0 || redirect_valid !== 0) begin
      bad++;
      $display("FAIL drop_quiet: tv=%b rv=%b want 0 0",
               trap_valid, redirect_valid);
    end
  endtask

  task automatic test_drain_exc;
    do_reset();
    pmode = 2'd3; mstatus_mie = 1; mie = 64'h80;
    mtvec = 64'h8000_0001; irq_mti = 1;
    tick(); tick();
    exc_valid = 1; exc_code = 6'd5; exc_pc = 64'h2000;
    drain_ack = 1; drain_pc = 64'h9999;
    tick();
    exc_valid = 0; drain_ack = 0; irq_mti = 0;
    total++;
    if (trap_valid !== 1 || trap_code !== 6'd5 ||
        trap_is_exc !== 1 || trap_pc !== 64'h2000) begin
      bad++;
      $display("FAIL drain_exc: tv=%b code=%0d exc=%b pc=%h want 1 5 1 2000",
               trap_valid, trap_code, trap_is_exc, trap_pc);
    end
    tick();
    total++;
    if (redirect_valid !== 1 || redirect_pc !== 64'h8000_0000) begin
      bad++;
      $display("FAIL drain_exc_redir: rv=%b rpc=%h want 1 80000000",
               redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_rst_commit;
    do_reset();
    mtvec = 64'h4000;
    exc_valid = 1; exc_code = 6'd3; exc_pc = 64'h50;
    tick();
    exc_valid = 0;
    total++;
    if (trap_valid !== 1) begin
      bad++;
      $display("FAIL rstc_pre: tv=%b want 1", trap_valid);
    end
    rst = 1; irq_mti = 1;
    tick();
    rst = 0;
    total++;
    if ({stall_req, busy, trap_valid, redirect_valid} !== 4'b0 ||
        trap_code !== 6'd0 || trap_is_exc !== 0 ||
        trap_pc !== 64'd0 || redirect_pc !== 64'd0 ||
        mip_view !== 64'd0) begin
      bad++;
      $display("FAIL rstc_zero: st=%b bz=%b tv=%b rv=%b code=%0d pc=%h rpc=%h mip=%h want all 0",
               stall_req, busy, trap_valid, redirect_valid,
               trap_code, trap_pc, redirect_pc, mip_view);
    end
    tick();
    total++;
    if (redirect_valid !== 0 || trap_valid !== 0 || busy !== 0) begin
      bad++;
      $display("FAIL rstc_after: rv=%b tv=%b busy=%b want 0 0 0",
               redirect_valid, trap_valid, busy);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    mtvec = 64'hFFFF_FFFF_FFFF_FFFD;
    mie = 64'h800; irq_mei = 1; pmode = 2'd0;
    tick(); tick();
    drain_ack = 1; drain_pc = 64'h8;
    tick();
    drain_ack = 0; irq_mei = 0;
    tick();
    total++;
    if (redirect_valid !== 1 || redirect_pc !== 64'h28) begin
      bad++;
      $display("FAIL wrap_rpc: rv=%b rpc=%h want 1 28",
               redirect_valid, redirect_pc);
    end
  endtask

  // Model tracks a waiting interrupt and the remaining
  // commit/redirect cycles of the trap in flight.
  task automatic test_random;
    logic [63:0] m_mip, m_pc, m_rpc, pend;
    logic [5:0]  m_code, code;
    logic        m_exc, m_wait, take;
    logic        e_tv, e_rv, e_st;
    int          m_left;
    do_reset();
    m_mip = 0; m_pc = 0; m_rpc = 0; m_code = 0;
    m_exc = 0; m_wait = 0; m_left = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      pmode = 2'($urandom_range(0, 3));
      mstatus_mie = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0)
        mie = {$urandom, $urandom};
      if ($urandom_range(0, 9) == 0) irq_msi = ~irq_msi;
      if ($urandom_range(0, 9) == 0) irq_mti = ~irq_mti;
      if ($urandom_range(0, 9) == 0) irq_mei = ~irq_mei;
      if ($urandom_range(0, 29) == 0)
        mtvec = {$urandom, $urandom};
      exc_valid = ($urandom_range(0, 15) == 0);
      exc_code = 6'($urandom);
      exc_pc = {$urandom, $urandom};
      drain_ack = ($urandom_range(0, 3) == 0);
      drain_pc = {$urandom, $urandom};
      pend = m_mip & mie;
      take = (pend != 0) && (pmode == 0 || mstatus_mie);
      code = pend[11] ? 6'd11 : (pend[3] ? 6'd3 : 6'd7);
      if (rst) begin
        m_mip = 0; m_pc = 0; m_rpc = 0; m_code = 0;
        m_exc = 0; m_wait = 0; m_left = 0;
      end else begin
        if (m_left == 2) begin
          m_left = 1;
          m_rpc = {mtvec[63:2], 2'b00};
          if (mtvec[1:0] == 2'd1 && !m_exc)
            m_rpc = m_rpc + 64'(m_code) * 64'd4;
        end else if (m_left == 1) begin
          m_left = 0;
        end else if (exc_valid) begin
          m_code = exc_code; m_pc = exc_pc; m_exc = 1;
          m_wait = 0; m_left = 2;
        end else if (m_wait) begin
          if (!take) m_wait = 0;
          else if (drain_ack) begin
            m_pc = drain_pc; m_wait = 0; m_left = 2;
          end else m_code = code;
        end else if (take) begin
          m_code = code; m_exc = 0; m_wait = 1;
        end
        m_mip = 0;
        m_mip[3] = irq_msi;
        m_mip[7] = irq_mti;
        m_mip[11] = irq_mei;
      end
      tick();
      e_tv = (m_left == 2);
      e_rv = (m_left == 1);
      e_st = m_wait || (m_left != 0);
      total++;
      if ({stall_req, busy, trap_valid, redirect_valid} !==
          {e_st, e_st, e_tv, e_rv} || mip_view !== m_mip) begin
        bad++;
        $display("FAIL rand_ctl c=%0d: st/bz/tv/rv=%b%b%b%b mip=%h want %b%b%b%b %h",
                 c, stall_req, busy, trap_valid, redirect_valid,
                 mip_view, e_st, e_st, e_tv, e_rv, m_mip);
      end
      if (e_tv) begin
        total++;
        if (trap_code !== m_code || trap_is_exc !== m_exc ||
            trap_pc !== m_pc) begin
          bad++;
          $display("FAIL rand_trap c=%0d: code=%0d exc=%b pc=%h want %0d %b %h",
                   c, trap_code, trap_is_exc, trap_pc,
                   m_code, m_exc, m_pc);
        end
      end
      if (e_rv) begin
        total++;
        if (redirect_pc !== m_rpc) begin
          bad++;
          $display("FAIL rand_redir c=%0d: rpc=%h want %h",
                   c, redirect_pc, m_rpc);
        end
      end
    end
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    test_reset();
    test_exc();
    test_int_vec();
    test_priority();
    test_gate();
    test_drop();
    test_drain_exc();
    test_rst_commit();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter VECTOR_EN, default 1, enables vectored mtvec dispatch for interrupts.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 pmode  input  2  current privilege mode (0 = U, 3 = M).
REQ-005 mstatus_mie  input  1  global M-mode interrupt enable.
REQ-006 mie  input  64  interrupt-enable CSR; only bits 3, 7, 11 are used.
REQ-007 irq_msi, irq_mti, irq_mei  input  1 each  software, timer and external interrupt levels.
REQ-008 mtvec  input  64  trap-vector CSR.
REQ-009 exc_valid  input  1  a synchronous exception is presented this cycle.
REQ-010 exc_code  input  6  exception cause; exc_pc  input  64  faulting pc.
REQ-011 drain_ack  input  1  pipeline drained; drain_pc  input  64  pc of oldest unretired instruction, valid with drain_ack.
REQ-012 stall_req  output  1  freeze fetch and issue.
REQ-013 trap_valid  output  1  one-cycle trap commit to the CSR file.
REQ-014 trap_code  output  6; trap_is_exc  output  1; trap_pc  output  64  trap commit payload.
REQ-015 redirect_valid  output  1; redirect_pc  output  64  one-cycle fetch redirect.
REQ-016 mip_view  output  64  registered pending bits: bit 3 = msi, bit 7 = mti, bit 11 = mei, all other bits 0.
REQ-017 busy  output  1  state is not IDLE.

Function
REQ-018 mip_view SHALL register the irq lines every cycle (1-cycle latency), independent of state.
REQ-019 pending = mip_view & mie; the selected interrupt priority SHALL be 11 > 3 > 7.
REQ-020 take_int SHALL be asserted when pending is nonzero and either pmode == 0 or mstatus_mie == 1.
REQ-021 The FSM SHALL have the states IDLE, DRAIN, COMMIT and REDIR, with all outputs registered (Moore).
REQ-022 IDLE: exc_valid SHALL latch {exc_code, exc_pc, is_exc = 1} and go to COMMIT; otherwise take_int SHALL latch the selected code with is_exc = 0 and go to DRAIN; exc_valid wins if both hold in the same cycle.
REQ-023 DRAIN: stall_req SHALL be 1.
  - exc_valid SHALL override and take the IDLE exception path.
  - Otherwise, if take_int drops, the FSM SHALL return to IDLE.
  - Otherwise drain_ack SHALL latch drain_pc and go to COMMIT.
  - Otherwise the FSM SHALL re-latch the highest-priority code and stay in DRAIN.
REQ-024 COMMIT: trap_valid = 1 for exactly one cycle with the latched payload, stall_req = 1, next state REDIR.
REQ-025 REDIR: redirect_valid = 1 for exactly one cycle, stall_req = 1, next state IDLE.
REQ-026 In COMMIT and REDIR, exc_valid and drain_ack SHALL be ignored.
REQ-027 redirect_pc base = {mtvec[63:2], 2'b00}.
  - If VECTOR_EN, mtvec[1:0] == 1 and !is_exc: redirect_pc = base + (code << 2).
  - Otherwise redirect_pc = base; modes 2 and 3 are treated as direct.
  - The addition SHALL be 64-bit and wrap modulo 2^64.
REQ-028 Exception latency: exc_valid in cycle N -> trap_valid in N+1 -> redirect_valid in N+2.
REQ-029 Interrupt latency:
  - irq asserted in cycle N -> stall_req in N+2.
  - drain_ack in cycle M -> trap_valid in M+1 -> redirect_valid in M+2.
REQ-030 trap_valid and redirect_valid SHALL never be high in the same cycle; at most one trap SHALL be in flight.

Reset
REQ-031 On rst, in the same clock edge: state = IDLE; all outputs = 0, including mip_view, latched code and pc.
REQ-032 rst asserted in any state SHALL abort the trap in progress with no trap_valid or redirect_valid pulse.

Verification
REQ-033 Bench SHALL cover: exc_valid in IDLE with code 2, pc 0x8000_0010 -> trap_valid next cycle {2, 1, 0x8000_0010}, then redirect_pc = mtvec base.
REQ-034 Bench SHALL cover: pmode 3, mstatus_mie 1, mie[7] = 1, irq_mti = 1, mtvec 0x8000_0001; drain_ack with drain_pc 0x100 -> trap {7, 0, 0x100}, redirect_pc 0x8000_001C.
REQ-035 Bench SHALL cover: irq_mti and irq_mei raised together -> code 11 committed; also mei raised mid-DRAIN after mti -> code 11 committed.
REQ-036 Bench SHALL cover: pmode 3, mstatus_mie 0, pending MTI -> stays IDLE; with pmode 0 -> trap taken.
REQ-037 Bench SHALL cover: in DRAIN, irq drops -> back to IDLE with no trap_valid; in DRAIN, exc_valid code 5 -> exception committed instead of the interrupt.
REQ-038 Bench SHALL cover: rst pulsed during COMMIT -> no trap_valid or redirect_valid, all outputs 0 next cycle.
